// File: rtl/speedavg_pkg.sv
// Shared constants and FSM encoding for the windowed wind-speed averager.
package speedavg_pkg;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned FRAC_W      = 10;
  localparam int unsigned MAXLOG2_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/speedavg_ram.sv
// Sample-pair circular buffer: one synchronous write port, one synchronous read port.
module speedavg_ram
  import speedavg_pkg::*;
#(
  parameter int unsigned AW = MAXLOG2_DEF,
  parameter int unsigned DW = 2 * SAMPLE_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Read-before-write: a same-address read returns the old entry (full-depth window).
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/speedavg.sv
// Sliding-window mean of 2^Le wind-speed pairs, avgen 3 clocks after speeden.
// Define SPEEDAVG_ROUND_EN for round-half-up output; default truncates.
module speedavg
  import speedavg_pkg::*;
#(
  parameter int unsigned MAXLOG2 = MAXLOG2_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       speeden,
  input  logic signed [SAMPLE_W-1:0] speedX,
  input  logic signed [SAMPLE_W-1:0] speedY,
  input  logic [3:0]                 spdmeanlen,
  output logic signed [SAMPLE_W-1:0] avgX,
  output logic signed [SAMPLE_W-1:0] avgY,
  output logic                       avgen,
  output logic                       ovf
);

  localparam int unsigned AW    = MAXLOG2;
  localparam int unsigned SUM_W = SAMPLE_W + MAXLOG2;
  localparam logic [3:0]  MAXLE = 4'(MAXLOG2);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t                     state_q;
  logic [AW-1:0]              wrptr_q;
  logic [AW:0]                fill_q, fill_d;
  logic signed [SUM_W-1:0]    sumx_q, sumy_q, sumx_d, sumy_d;
  logic signed [SAMPLE_W-1:0] newx_q, newy_q, avgx_q, avgy_q, avgx_d, avgy_d;
  logic [3:0]                 le_q, le_prev_q, le_in;
  logic                       restart_q, avgen_q, ovf_q;

  logic [AW:0]                win_len;
  logic [AW-1:0]              raddr;
  logic [2*SAMPLE_W-1:0]      rd_data;
  logic                       leave_en;
  logic signed [SUM_W-1:0]    newx_ext, newy_ext, leavex_ext, leavey_ext, rnd;

  assign le_in   = (spdmeanlen > MAXLE) ? MAXLE : spdmeanlen;
  assign win_len = {{AW{1'b0}}, 1'b1} << le_q;
  assign raddr   = wrptr_q - win_len[AW-1:0];

  speedavg_ram #(
    .AW(AW),
    .DW(2 * SAMPLE_W)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (state_q == ST_READ),
    .waddr_i(wrptr_q),
    .wdata_i({newy_q, newx_q}),
    .raddr_i(raddr),
    .rdata_o(rd_data)
  );

  // A restart discards the old window, so nothing leaves until it refills.
  assign leave_en   = !restart_q && (fill_q >= win_len);
  assign newx_ext   = {{MAXLOG2{newx_q[SAMPLE_W-1]}}, newx_q};
  assign newy_ext   = {{MAXLOG2{newy_q[SAMPLE_W-1]}}, newy_q};
  assign leavex_ext = leave_en ? {{MAXLOG2{rd_data[SAMPLE_W-1]}}, rd_data[SAMPLE_W-1:0]} : '0;
  assign leavey_ext = leave_en ? {{MAXLOG2{rd_data[2*SAMPLE_W-1]}}, rd_data[2*SAMPLE_W-1:SAMPLE_W]} : '0;

  always_comb begin
    sumx_d = (restart_q ? '0 : sumx_q) + newx_ext - leavex_ext;
    sumy_d = (restart_q ? '0 : sumy_q) + newy_ext - leavey_ext;
    fill_d = fill_q;
    if (restart_q)            fill_d = {{AW{1'b0}}, 1'b1};
    else if (fill_q != DEPTH) fill_d = fill_q + {{AW{1'b0}}, 1'b1};
  end

`ifdef SPEEDAVG_ROUND_EN
  assign rnd = (le_q == '0) ? '0 : (SUM_W'(1) << (le_q - 4'd1));
`else
  assign rnd = '0;
`endif

  assign avgx_d = SAMPLE_W'((sumx_q + rnd) >>> le_q);
  assign avgy_d = SAMPLE_W'((sumy_q + rnd) >>> le_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wrptr_q   <= '0;
      fill_q    <= '0;
      sumx_q    <= '0;
      sumy_q    <= '0;
      newx_q    <= '0;
      newy_q    <= '0;
      le_q      <= '0;
      le_prev_q <= '0;
      restart_q <= 1'b0;
      avgx_q    <= '0;
      avgy_q    <= '0;
      avgen_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      avgen_q <= 1'b0;
      if (speeden && state_q != ST_IDLE) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (speeden) begin
            newx_q    <= speedX;
            newy_q    <= speedY;
            le_q      <= le_in;
            le_prev_q <= le_in;
            restart_q <= (le_in != le_prev_q);
            state_q   <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_ACCUM;
        ST_ACCUM: begin
          sumx_q  <= sumx_d;
          sumy_q  <= sumy_d;
          fill_q  <= fill_d;
          wrptr_q <= wrptr_q + AW'(1);
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (fill_q >= win_len) begin
            avgen_q <= 1'b1;
            avgx_q  <= avgx_d;
            avgy_q  <= avgy_d;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avgX  = avgx_q;
  assign avgY  = avgy_q;
  assign avgen = avgen_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_speedavg.sv
// Scoreboard bench for speedavg: directed vectors, monitor compares every avgen pulse.
module tb_speedavg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        speeden = 1'b0;
  logic [15:0] speedX = '0;
  logic [15:0] speedY = '0;
  logic [3:0]  spdmeanlen = '0;
  logic [15:0] avgX, avgY;
  logic        avgen, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef SPEEDAVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          at;
  } exp_t;
  exp_t sb[$];

  speedavg #(.MAXLOG2(6)) dut (
    .clock     (clk),
    .reset     (reset),
    .speeden   (speeden),
    .speedX    (speedX),
    .speedY    (speedY),
    .spdmeanlen(spdmeanlen),
    .avgX      (avgX),
    .avgY      (avgY),
    .avgen     (avgen),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (avgen) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_avgen: got avgX=%h avgY=%h at cycle %0d, none expected", avgX, avgY, cyc);
      end else begin
        e = sb.pop_front();
        if (avgX !== e.x || avgY !== e.y || cyc != e.at) begin
          errors++;
          $display("FAIL avg_out: got X=%h Y=%h cycle %0d, expected X=%h Y=%h cycle %0d",
                   avgX, avgY, cyc, e.x, e.y, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] len,
                      input bit exp, input logic [15:0] ex, input logic [15:0] ey);
    @(negedge clk);
    speedX = x; speedY = y; spdmeanlen = len; speeden = 1'b1;
    if (exp) sb.push_back('{ex, ey, cyc + 4});
    @(negedge clk);
    speeden = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_avgX", avgX, 16'h0000);
    check("rst_avgY", avgY, 16'h0000);
    check("rst_avgen", {15'd0, avgen}, 16'h0000);
    check("rst_ovf", {15'd0, ovf}, 16'h0000);

    // Le=0: output equals input
    send(16'h0400, 16'hFC00, 4'd0, 1'b1, 16'h0400, 16'hFC00);

    // Le=2: 4,8,12,16 -> 10; then 20 -> 14
    send(16'd4,  -16'sd4,  4'd2, 1'b0, '0, '0);
    send(16'd8,  -16'sd8,  4'd2, 1'b0, '0, '0);
    send(16'd12, -16'sd12, 4'd2, 1'b0, '0, '0);
    send(16'd16, -16'sd16, 4'd2, 1'b1, 16'd10, -16'sd10);
    send(16'd20, -16'sd20, 4'd2, 1'b1, 16'd14, -16'sd14);

    // Le 2->3 after 5 samples: window restarts, 8 fresh samples needed
    for (int i = 1; i <= 7; i++) send(16'(2 * i), 16'd8, 4'd3, 1'b0, '0, '0);
    send(16'd16, 16'd8, 4'd3, 1'b1, 16'd9, 16'd8);
    send(16'd18, 16'd8, 4'd3, 1'b1, 16'd11, 16'd8);

    // Le=1: -3,-2 -> -3 truncated, -2 rounded; Y 5,6 -> 5 / 6
    send(-16'sd3, 16'd5, 4'd1, 1'b0, '0, '0);
    send(-16'sd2, 16'd6, 4'd1, 1'b1, ROUND ? -16'sd2 : -16'sd3, ROUND ? 16'd6 : 16'd5);
    check("ovf_before_drop", {15'd0, ovf}, 16'h0000);

    // Two pulses 2 clocks apart: second dropped, one avgen (window {-2,10}->4, {6,20}->13)
    @(negedge clk);
    speedX = 16'd10; speedY = 16'd20; speeden = 1'b1;
    sb.push_back('{16'd4, 16'd13, cyc + 4});
    @(negedge clk); speeden = 1'b0;
    @(negedge clk); speedX = 16'd99; speedY = 16'd99; speeden = 1'b1;
    @(negedge clk); speeden = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_set", {15'd0, ovf}, 16'h0001);
    send(16'd0, 16'd0, 4'd1, 1'b1, 16'd5, 16'd10);
    check("ovf_sticky", {15'd0, ovf}, 16'h0001);

    // Reset while in ACCUM: no avgen afterwards, ovf cleared
    @(negedge clk);
    speedX = 16'd7; speedY = 16'd7; spdmeanlen = 4'd0; speeden = 1'b1;
    @(negedge clk); speeden = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_avgX", avgX, 16'h0000);
    check("abort_ovf", {15'd0, ovf}, 16'h0000);

    // Le=6: 70 full-scale samples, then pointer-wrap and Le-clamp probes
    for (int i = 1; i <= 70; i++)
      send(16'h7FFF, 16'h8001, 4'd6, i >= 64, 16'h7FFF, 16'h8001);
    send(16'h0000, 16'h8001, 4'd6, 1'b1, 16'h7DFF, 16'h8001);
    send(16'h0000, 16'h8001, 4'd15, 1'b1, 16'h7BFF, 16'h8001);

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    do_reset();
    check("final_rst_avgY", avgY, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speedavg.md
SPEEDAVG -- requirements
Module: speedavg

Interface
REQ-001 SHALL have parameter MAXLOG2, default 6, meaning log2 of the buffer depth (max window length 64).
REQ-002 SHALL have port clock, input, 1, single system clock (2 MHz domain); all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port speeden, input, 1, one-clock pulse qualifying speedX/speedY.
REQ-005 SHALL have ports speedX and speedY, input, 16 each, signed wind speed, 10 fractional bits.
REQ-006 SHALL have port spdmeanlen, input, 4, log2 of the requested window length N.
REQ-007 SHALL have ports avgX and avgY, output, 16 each, signed windowed mean, same format as the inputs.
REQ-008 SHALL have port avgen, output, 1, one-clock pulse marking a new avgX/avgY.
REQ-009 SHALL have port ovf, output, 1, sticky flag for a dropped input pulse.

Function
REQ-010 SHALL use effective length Le = min(spdmeanlen, MAXLOG2) and window L = 2^Le.
REQ-011 SHALL store each accepted sample pair in a circular buffer of 2^MAXLOG2 entries, with write pointer wrapping modulo depth.
REQ-012 SHALL run the FSM IDLE -> READ -> ACCUM -> OUT -> IDLE, advancing one state per clock after speeden is accepted in IDLE.
REQ-013 In READ, SHALL read the entry at (wrptr - L) mod depth, the sample leaving the window, and write the new sample at wrptr.
REQ-014 In ACCUM, SHALL update each sum: sum <= sum + new - leaving; leaving is 0 while fill count < L.
REQ-015 SHALL size each sum as signed 16+MAXLOG2 bits so it never overflows.
REQ-016 In OUT, SHALL form avgX/avgY = sum >>> Le (arithmetic shift, low 16 bits), registered.
REQ-017 SHALL pulse avgen for one clock in OUT only when fill count >= L; avgX/avgY SHALL hold between pulses.
REQ-018 Latency SHALL be exactly 3 clocks from the speeden edge to avgen, and Le=0 SHALL give avgX=speedX.
REQ-019 SHALL saturate fill count at 2^MAXLOG2.
REQ-020 SHALL ignore speeden arriving outside IDLE and set ovf, which stays set until reset.
REQ-021 SHALL sample Le in IDLE; a change of Le from the previous accepted sample SHALL clear both sums and the fill count before the new sample is accumulated (restart of window), and the buffer contents SHALL be left untouched.

Reset
REQ-022 Reset SHALL set avgX=0, avgY=0, avgen=0, ovf=0, sums=0, fill count=0, wrptr=0 and state=IDLE.
REQ-023 Reset asserted mid-operation SHALL abort the FSM with no avgen pulse in that or the following cycle.
REQ-024 Buffer RAM contents SHALL not require reset.

Configuration
REQ-025 With SPEEDAVG_ROUND_EN defined, OUT SHALL add 2^(Le-1) before the shift when Le>0 (round half up).
REQ-026 Without SPEEDAVG_ROUND_EN, OUT SHALL truncate toward minus infinity.

Structure
REQ-027 Shared package SHALL hold the sample width (16), fractional bits (10), MAXLOG2 default and the FSM state encoding.
REQ-028 Buffer SHALL be sub-module speedavg_ram: 32-bit wide, one synchronous write port and one synchronous read port, inferred as block RAM.

Verification
REQ-029 Le=0, speedX=0x0400, speedY=0xFC00 -> avgX=0x0400, avgY=0xFC00, avgen 3 clocks after speeden.
REQ-030 Le=2, speedX inputs 4,8,12,16 -> no avgen for the first 3, then avgX=10; a fifth input of 20 gives 14.
REQ-031 Le=1, speedX inputs -3,-2 -> avgX=-3 without the macro and -2 with SPEEDAVG_ROUND_EN.
REQ-032 Two speeden pulses 2 clocks apart -> second dropped, ovf=1, one avgen only; ovf cleared only by reset.
REQ-033 Le=6, 70 inputs of 0x7FFF -> avgX=0x7FFF (no overflow), and the write pointer wraps correctly.
REQ-034 Change spdmeanlen 2->3 after 5 samples -> no avgen until 8 new samples, then the mean of those 8 only; reset in ACCUM -> no avgen.
